seg_scan_capture: RTL
=====================

# seg_scan_capture

Receive-side counterpart of the 4-digit multiplexed seven-segment driver. Watches the active-low anode strobes and the active-low cathode lines and waits for each digit to hold steady. It then decodes each glyph back to BCD and reassembles the 16-bit value that was displayed. Used as an on-chip loopback monitor and as a bench checker for the display path.

## Interface
- STABLE_CYCLES, 512, cycles the anode and cathode buses must hold unchanged before a digit is sampled. Legal range 2..1024, which suits the driver's 1024-cycle digit period.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_anode_in  input  4  anode strobes, active low; 1110 = digit0 … 0111 = digit3.
- seg_cathode_in  input  7  cathodes, active low, ordered {g,f,e,d,c,b,a}.
- bcd_out  output  16  last complete frame: digit0 in [3:0], digit1 in [7:4], digit2 in [11:8], digit3 in [15:12].
- frame_valid  output  1  one-cycle pulse when bcd_out is updated.
- frame_err  output  1  one-cycle pulse on a scan-order violation.
- glyph_err  output  1  one-cycle pulse when an undecodable glyph is sampled.

## Operation
- The anode and cathode buses are compared against their values from the previous cycle. "Change" means any bit differs.
- Glyph decode (active-low cathode value → nibble):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - 7F (blank) → F, with no error.
  - Any other value → F, and glyph_err pulses.
- The FSM has three states, HUNT, SETTLE and HOLD, plus a 2-bit expected-digit index `idx`.
- HUNT:
  - Wait for anode == 1110.
  - On that value, set idx=0, clear the counter, and go to SETTLE.
- SETTLE:
  - The counter increments each cycle.
  - A cathode change clears the counter and the FSM stays in SETTLE.
  - An anode change pulses frame_err and the FSM goes to HUNT.
  - When counter == STABLE_CYCLES-1 with no change in that cycle:
    - Decode the glyph and write it into shadow nibble idx.
    - If idx==3, also load bcd_out with {decoded, shadow[11:0]} and pulse frame_valid.
    - Go to HOLD.
- HOLD:
  - Cathode changes are ignored, and so is anode == 1111 (blanking).
  - If the anode changes to the pattern for digit (idx+1) mod 4, advance idx, clear the counter, and go to SETTLE.
  - A change to any other pattern, including multiple lows or a skipped or repeated digit, pulses frame_err and the FSM goes to HUNT.
- Shadow contents survive errors. bcd_out changes only on a complete, in-order frame that begins at digit0.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=HUNT, idx=0, counter=0, shadow=0
  - bcd_out=16'h0000
  - frame_valid=0, frame_err=0, glyph_err=0
- Sampling happens after STABLE_CYCLES consecutive cycles with no change on either bus (post-synchronizer) while in SETTLE.
- All outputs are registered. Each pulse is high for exactly the one cycle after the edge that causes it.
- frame_valid and glyph_err can pulse in the same cycle, when digit3 is undecodable.
- Counter width is 10 bits and never wraps. SETTLE leaves at STABLE_CYCLES-1.
- A digit held for less than STABLE_CYCLES cycles is never sampled. The resulting anode change in SETTLE produces frame_err.
- Reset asserted mid-frame discards the partial frame. After release, capture restarts in HUNT.

## Configuration
- SEG_SCAN_CAPTURE_SYNC_EN defined: both input buses pass through a 2-flop synchronizer, adding 2 cycles of latency to every event. Use this setting for pins or an asynchronous source.
- SEG_SCAN_CAPTURE_SYNC_EN undefined: the inputs are used directly (same-clock loopback), with 0 extra cycles. The FSM behaviour is otherwise identical.

## Test plan
- Frame test: drive 1110/glyph 1, 1101/glyph 2, 1011/glyph 3, 0111/glyph 4 for 1024 cycles each. Required: bcd_out=16'h4321, with frame_valid pulsing once, 512 cycles into digit3 plus synchronizer latency.
- Mid-frame start: begin the scan at anode 1011 with values 5,6,7,8. Required: no capture until 1110 is seen, and the first frame_valid comes only after the following 0111 digit.
- Skipped digit: change the anode from 1110 directly to 1011. Required: one frame_err pulse, bcd_out unchanged, and the FSM back in HUNT.
- Cathode glitch: flip the cathode for one cycle, 300 cycles into a digit. Required: the sample lands 512 cycles after the glitch rather than at cycle 512, and the decoded value is still correct.
- Bad glyph: set the cathode to 7'h7E on digit2 of the frame 1,2,X,4. Required: glyph_err pulse and bcd_out=16'h4F21. A blank glyph (7'h7F) gives the same F with no glyph_err.
- Reset: assert rst during SETTLE of digit3 after one good frame. Required: bcd_out=0 and all pulses low immediately, and no frame_valid until a fresh full frame completes.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Loopback monitor for a 4-digit multiplexed seven-segment display.
//   Waits for each digit's anode/cathode pattern to hold steady, decodes
//   the glyph back to BCD and publishes a 16-bit value once a complete,
//   in-order frame (digit0..digit3) has been observed.
//
// Configuration macro:
//   SEG_SCAN_CAPTURE_SYNC_EN  defined   -> both input buses pass through a
//                                          2-flop synchronizer (+2 cycles)
//                             undefined -> inputs used directly
//
// Parameters:
//   STABLE_CYCLES   cycles both buses must hold unchanged before a digit is
//                   sampled (legal 2..1024)
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   seg_anode_in    [3:0] anode strobes, active low (1110 = digit0)
//   seg_cathode_in  [6:0] cathodes, active low, {g,f,e,d,c,b,a}
//   bcd_out         [15:0] last complete frame, digit0 in [3:0]
//   frame_valid     one-cycle pulse when bcd_out updates
//   frame_err       one-cycle pulse on a scan-order violation
//   glyph_err       one-cycle pulse when an undecodable glyph is sampled
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_anode_in,
  input  logic [6:0]  seg_cathode_in,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        glyph_err
);

  localparam logic [9:0] LAST_CNT = 10'(STABLE_CYCLES - 1);
  localparam logic [3:0] ANODE_IDLE = 4'hF;
  localparam logic [6:0] CATH_IDLE  = 7'h7F;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [9:0]  cnt;
  logic [15:0] shadow;

  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic [3:0]  anode_last;
  logic [6:0]  cathode_last;
  logic        anode_chg;
  logic        cathode_chg;
  logic [4:0]  dec;

  // Active-low cathode pattern -> {error, nibble}; blank decodes to F cleanly.
  function automatic logic [4:0] decode_glyph(input logic [6:0] cath);
    case (cath)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      7'h7F:   return 5'h0F;
      default: return 5'h1F;
    endcase
  endfunction

  // Anode pattern that selects digit i (single active-low strobe).
  function automatic logic [3:0] anode_for(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  // ---- input stage: optional synchronizer ----
`ifdef SEG_SCAN_CAPTURE_SYNC_EN
  logic [3:0] anode_p0, anode_p1;
  logic [6:0] cathode_p0, cathode_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_p0   <= ANODE_IDLE;
      anode_p1   <= ANODE_IDLE;
      cathode_p0 <= CATH_IDLE;
      cathode_p1 <= CATH_IDLE;
    end else begin
      anode_p0   <= seg_anode_in;
      anode_p1   <= anode_p0;
      cathode_p0 <= seg_cathode_in;
      cathode_p1 <= cathode_p0;
    end
  end

  assign anode   = anode_p1;
  assign cathode = cathode_p1;
`else
  assign anode   = seg_anode_in;
  assign cathode = seg_cathode_in;
`endif

  // ---- change-detect stage: compare against previous cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_last   <= ANODE_IDLE;
      cathode_last <= CATH_IDLE;
    end else begin
      anode_last   <= anode;
      cathode_last <= cathode;
    end
  end

  assign anode_chg   = (anode != anode_last);
  assign cathode_chg = (cathode != cathode_last);
  assign dec         = decode_glyph(cathode);

  // ---- capture FSM and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      idx         <= 2'd0;
      cnt         <= 10'd0;
      shadow      <= 16'h0000;
      bcd_out     <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      glyph_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      glyph_err   <= 1'b0;
      case (state)
        HUNT: begin
          if (anode == 4'b1110) begin
            idx   <= 2'd0;
            cnt   <= 10'd0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // An anode change wins over a simultaneous cathode change.
          if (anode_chg) begin
            frame_err <= 1'b1;
            state     <= HUNT;
          end else if (cathode_chg) begin
            cnt <= 10'd0;
          end else if (cnt == LAST_CNT) begin
            shadow[{idx, 2'b00} +: 4] <= dec[3:0];
            glyph_err                 <= dec[4];
            if (idx == 2'd3) begin
              bcd_out     <= {dec[3:0], shadow[11:0]};
              frame_valid <= 1'b1;
            end
            state <= HOLD;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        HOLD: begin
          // Blanking (all anodes off) between digits is tolerated.
          if (anode_chg && (anode != ANODE_IDLE)) begin
            if (anode == anode_for(idx + 2'd1)) begin
              idx   <= idx + 2'd1;
              cnt   <= 10'd0;
              state <= SETTLE;
            end else begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
